wb_mem_bist: RTL

Wishbone pipelined initiator that runs a fill-then-verify self-test on one port of the banked dual-port RAM. It writes a seed-derived pattern across a programmable address window, then reads the window back and compares each word. It reports pass/fail, the error count and the first failing address. It sits between the test/control logic and a RAM port (A or B), and exercises that port's stall/ack handshake, including bank-conflict stalls caused by traffic on the other port.

---
 rtl/wb_bist_pkg.sv | 24 ++
 rtl/wb_outstanding_ctr.sv | 42 ++++
 rtl/wb_mem_bist.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wb_bist_pkg.sv
// Shared types, widths and the test-pattern generator for the Wishbone memory BIST.
package wb_bist_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_WAIT,
        RD,
        RD_WAIT,
        FIN
    } bistState_t;

    // Word written at window offset idx: seed + idx, wrapping at 2^DATA_W.
    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] seedVal,
                                                  input logic [IDX_W-1:0]  idx);
        return seedVal + DATA_W'(idx);
    endfunction

endpackage

// File: rtl/wb_outstanding_ctr.sv
// Saturating count of accepted-but-unacknowledged Wishbone requests.
module wb_outstanding_ctr
    import wb_bist_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic [CNT_W-1:0] countNext_c
);

    logic doInc;
    logic doDec;

    // Next count; an ack with nothing outstanding is dropped, accept+ack cancels.
    always_comb begin
        doInc       = inc && (count != CNT_W'(MAX_OUT));
        doDec       = dec && (count != '0);
        countNext_c = count;
        if (doInc && !doDec) begin
            countNext_c = count + CNT_W'(1);
        end else if (doDec && !doInc) begin
            countNext_c = count - CNT_W'(1);
        end
    end

    // Count and full flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= countNext_c;
            full  <= (countNext_c == CNT_W'(MAX_OUT));
        end
    end

endmodule

// File: rtl/wb_mem_bist.sv
// Wishbone pipelined initiator: fill a RAM window with seed+i, read it back, count mismatches.
module wb_mem_bist
    import wb_bist_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [3:0]        wb_sel_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic              wb_ack_i,
    input  logic              wb_stall_i,
    input  logic [DATA_W-1:0] wb_data_i
);

    bistState_t        state, stateN;
    logic [ADDR_W-1:0] baseR, baseN;
    logic [IDX_W-1:0]  countR, countN;
    logic [DATA_W-1:0] seedR, seedN;
    logic [IDX_W-1:0]  issueIdx, issueIdxN, issueInc;
    logic [IDX_W-1:0]  cmplIdx, cmplIdxN;
    logic [IDX_W-1:0]  errCntN;
    logic [ADDR_W-1:0] firstErrN;
    logic              passN, busyN, doneN, cycN, stbN, weN;
    logic [ADDR_W-1:0] addrN;
    logic [3:0]        selN;
    logic [DATA_W-1:0] dataN;
    logic              accept, ackValid;
    logic [CNT_W-1:0]  outCnt, outCntN;
    logic              outFull;

    assign accept   = wb_cyc_o && wb_stb_o && !wb_stall_i && !outFull;
    assign ackValid = wb_ack_i && (outCnt != '0);
    assign issueInc = issueIdx + IDX_W'(1);

    wb_outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_outCtr (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (accept),
        .dec         (wb_ack_i),
        .count       (outCnt),
        .full        (outFull),
        .countNext_c (outCntN)
    );

    // Next state, run bookkeeping and next values of every registered output.
    always_comb begin
        stateN    = state;
        baseN     = baseR;
        countN    = countR;
        seedN     = seedR;
        issueIdxN = issueIdx;
        cmplIdxN  = cmplIdx;
        errCntN   = err_count;
        firstErrN = first_err_addr;
        passN     = pass;

        unique case (state)
            IDLE: begin
                if (start) begin
                    baseN     = base_addr;
                    countN    = word_count;
                    seedN     = seed;
                    issueIdxN = '0;
                    cmplIdxN  = '0;
                    errCntN   = '0;
                    firstErrN = '0;
                    passN     = 1'b0;
                    stateN    = (word_count == '0) ? FIN : WR;
                end
            end
            WR: begin
                if (accept) begin
                    issueIdxN = issueInc;
                    if (issueInc == countR) stateN = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (outCntN == '0) begin
                    stateN    = RD;
                    issueIdxN = '0;
                end
            end
            RD: begin
                if (accept) begin
                    issueIdxN = issueInc;
                    if (issueInc == countR) stateN = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (outCntN == '0) stateN = FIN;
            end
            FIN: begin
                stateN = IDLE;
            end
            default: begin
                stateN = IDLE;
            end
        endcase

        // In-order read completions are checked against the pattern for their offset.
        if ((state == RD || state == RD_WAIT) && ackValid) begin
            cmplIdxN = cmplIdx + IDX_W'(1);
            if (wb_data_i != pattern(seedR, cmplIdx)) begin
                errCntN = err_count + IDX_W'(1);
                if (err_count == '0) firstErrN = baseR + ADDR_W'(cmplIdx);
            end
        end

        if (stateN == FIN) passN = (errCntN == '0);

        busyN = (stateN != IDLE);
        doneN = (stateN == FIN);
        cycN  = (stateN inside {WR, WR_WAIT, RD, RD_WAIT});
        stbN  = (stateN == WR || stateN == RD) && (issueIdxN < countN)
                && (outCntN < CNT_W'(MAX_OUT));
        weN   = stbN && (stateN == WR);
        addrN = stbN ? baseN + ADDR_W'(issueIdxN) : '0;
        selN  = stbN ? 4'hF : 4'h0;
        dataN = weN ? pattern(seedN, issueIdxN) : '0;
    end

    // State, run context and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            baseR          <= '0;
            countR         <= '0;
            seedR          <= '0;
            issueIdx       <= '0;
            cmplIdx        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_addr_o      <= '0;
            wb_sel_o       <= '0;
            wb_data_o      <= '0;
        end else begin
            state          <= stateN;
            baseR          <= baseN;
            countR         <= countN;
            seedR          <= seedN;
            issueIdx       <= issueIdxN;
            cmplIdx        <= cmplIdxN;
            err_count      <= errCntN;
            first_err_addr <= firstErrN;
            pass           <= passN;
            busy           <= busyN;
            done           <= doneN;
            wb_cyc_o       <= cycN;
            wb_stb_o       <= stbN;
            wb_we_o        <= weN;
            wb_addr_o      <= addrN;
            wb_sel_o       <= selN;
            wb_data_o      <= dataN;
        end
    end

endmodule
